// File: rtl/frame_sync.sv
// Receive-side frame aligner: hunts for the FAS (F6 F6 F6 28 28 28), rebuilds row/col, strips FAS bytes.
// Define FRAME_SYNC_ERR_CNT_EN to add the saturating o_fas_err_cnt output.
module frame_sync #(
  parameter int COLS      = 1024,
  parameter int BAD_LIMIT = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_frame_data,
  input  logic        i_frame_data_valid,
  output logic [7:0]  o_pyld_data,
  output logic        o_pyld_data_valid,
  output logic [1:0]  o_row_cnt,
  output logic [10:0] o_col_cnt,
  output logic        o_in_frame,
  output logic        o_fas_err,
  output logic        o_lof
`ifdef FRAME_SYNC_ERR_CNT_EN
  ,
  output logic [15:0] o_fas_err_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PRESYNC = 2'd1,
    ST_SYNC    = 2'd2
  } state_e;

  localparam logic [10:0] COL_LAST = 11'(COLS - 1);
  localparam logic [2:0]  BAD_MAX  = 3'(BAD_LIMIT);
  localparam logic [47:0] FAS_WORD = 48'hF6F6F6_282828;
  localparam logic [7:0]  FAS_A1   = 8'hF6;
  localparam logic [7:0]  FAS_A2   = 8'h28;

  state_e      state_q, state_d;
  logic [39:0] sr_q, sr_d;
  logic [1:0]  row_q, row_d;
  logic [10:0] col_q, col_d;
  logic        mis_q, mis_d;
  logic [2:0]  bad_q, bad_d;

  logic [7:0]  pyld_data_q, pyld_data_d;
  logic        pyld_vld_q, pyld_vld_d;
  logic [1:0]  out_row_q, out_row_d;
  logic [10:0] out_col_q, out_col_d;
  logic        in_frame_q, in_frame_d;
  logic        fas_err_q, fas_err_d;
  logic        lof_q, lof_d;

  logic        fas_pos;
  logic        check_pt;
  logic        byte_bad;
  logic        mis_now;
  logic        hunt_match;
  logic [1:0]  row_nxt;
  logic [10:0] col_nxt;

  // Position decode and the running FAS comparison for the current byte.
  always_comb begin
    fas_pos    = (row_q == 2'd0) && (col_q < 11'd6);
    check_pt   = (row_q == 2'd0) && (col_q == 11'd5);
    byte_bad   = i_frame_data != ((col_q < 11'd3) ? FAS_A1 : FAS_A2);
    mis_now    = byte_bad | (mis_q & (col_q != 11'd0));
    hunt_match = ({sr_q, i_frame_data} == FAS_WORD);
    if (col_q == COL_LAST) begin
      col_nxt = 11'd0;
      row_nxt = row_q + 2'd1;
    end else begin
      col_nxt = col_q + 11'd1;
      row_nxt = row_q;
    end
  end

  always_comb begin
    // NOTE: every variable gets its hold/idle value first, so no path can infer a latch.
    state_d     = state_q;
    sr_d        = sr_q;
    row_d       = row_q;
    col_d       = col_q;
    mis_d       = mis_q;
    bad_d       = bad_q;
    pyld_data_d = pyld_data_q;
    pyld_vld_d  = 1'b0;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    fas_err_d   = 1'b0;
    lof_d       = 1'b0;

    if (i_frame_data_valid) begin
      sr_d = {sr_q[31:0], i_frame_data};
      case (state_q)
        ST_HUNT: begin
          // The matching byte is col 5, so the next valid byte sits at row 0, col 6.
          if (hunt_match) begin
            state_d = ST_PRESYNC;
            row_d   = 2'd0;
            col_d   = 11'd6;
          end
        end
        ST_PRESYNC, ST_SYNC: begin
          row_d = row_nxt;
          col_d = col_nxt;
          if (fas_pos) begin
            mis_d = mis_now;
          end else begin
            pyld_vld_d  = 1'b1;
            pyld_data_d = i_frame_data;
            out_row_d   = row_q;
            out_col_d   = col_q;
          end
          if (check_pt) begin
            if (state_q == ST_PRESYNC) begin
              if (mis_now) begin
                state_d = ST_HUNT;
                row_d   = 2'd0;
                col_d   = 11'd0;
              end else begin
                state_d = ST_SYNC;
              end
            end else if (!mis_now) begin
              bad_d = 3'd0;
            end else begin
              fas_err_d = 1'b1;
              if (bad_q + 3'd1 >= BAD_MAX) begin
                state_d = ST_HUNT;
                lof_d   = 1'b1;
                bad_d   = 3'd0;
                row_d   = 2'd0;
                col_d   = 11'd0;
              end else begin
                bad_d = bad_q + 3'd1;
              end
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
          row_d   = 2'd0;
          col_d   = 11'd0;
        end
      endcase
    end

    in_frame_d = (state_d == ST_SYNC);
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    if (i_rst) begin
      state_q     <= ST_HUNT;
      // NOTE: the shift register is real state that must start empty, so it is reset, unlike a RAM.
      sr_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      mis_q       <= 1'b0;
      bad_q       <= '0;
      pyld_data_q <= '0;
      pyld_vld_q  <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      in_frame_q  <= 1'b0;
      fas_err_q   <= 1'b0;
      lof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      row_q       <= row_d;
      col_q       <= col_d;
      mis_q       <= mis_d;
      bad_q       <= bad_d;
      pyld_data_q <= pyld_data_d;
      pyld_vld_q  <= pyld_vld_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      in_frame_q  <= in_frame_d;
      fas_err_q   <= fas_err_d;
      lof_q       <= lof_d;
    end
  end

`ifdef FRAME_SYNC_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Steps together with the o_fas_err pulse; survives LOF, cleared only by reset.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (fas_err_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_fas_err_cnt = err_cnt_q;
`endif

  assign o_pyld_data       = pyld_data_q;
  assign o_pyld_data_valid = pyld_vld_q;
  assign o_row_cnt         = out_row_q;
  assign o_col_cnt         = out_col_q;
  assign o_in_frame        = in_frame_q;
  assign o_fas_err         = fas_err_q;
  assign o_lof             = lof_q;

endmodule
